// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction-fetch, data and SRAM signals around mem_arbiter.
// The slave modport is the arbiter's view; master is the CPU/SRAM side.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        dm_req;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        mem_read;
  logic [3:0]  mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        cpu_stall;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_dout,
    output if_rdata, if_done, dm_rdata, dm_done,
    output mem_read, mem_write, mem_addr, mem_din, cpu_stall
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_dout,
    input  if_rdata, if_done, dm_rdata, dm_done,
    input  mem_read, mem_write, mem_addr, mem_din, cpu_stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serializes IF and DM accesses onto one single-port SRAM with alternating
// priority on conflicts. Handshake: level req, held until a one-cycle done.
module mem_arbiter (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic [1:0]    state_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] din_q, din_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        if_done_q, if_done_d;
  logic        dm_done_q, dm_done_d;
  logic        if_elig, dm_elig, pick_dm;

  // A side being acknowledged this cycle is not yet eligible again.
  assign if_elig = bus.if_req & ~if_done_q;
  assign dm_elig = bus.dm_req & ~dm_done_q;
  assign pick_dm = (if_elig & dm_elig) ? ~last_grant_q : dm_elig;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    din_d        = din_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_done_d    = 1'b0;
    dm_done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_elig | dm_elig) begin
          grant_d      = pick_dm;
          last_grant_d = pick_dm;
          state_d      = ISSUE;
          if (pick_dm) begin
            addr_d = bus.dm_addr;
            we_d   = bus.dm_we;
            din_d  = bus.dm_wdata;
          end else begin
            addr_d = bus.if_addr;
            we_d   = 4'b0000;
          end
        end
      end
      ISSUE: begin
        if (we_q != 4'b0000) begin
          state_d   = IDLE;
          dm_done_d = 1'b1;
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (grant_q) begin
          dm_rdata_d = bus.mem_dout;
          dm_done_d  = 1'b1;
        end else begin
          if_rdata_d = bus.mem_dout;
          if_done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b0;
      addr_q       <= 32'd0;
      we_q         <= 4'd0;
      din_q        <= 32'd0;
      if_rdata_q   <= 32'd0;
      dm_rdata_q   <= 32'd0;
      if_done_q    <= 1'b0;
      dm_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      din_q        <= din_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_done_q    <= if_done_d;
      dm_done_q    <= dm_done_d;
    end
  end

  assign bus.mem_read  = (state_q == ISSUE) && (we_q == 4'b0000);
  assign bus.mem_write = (state_q == ISSUE) ? we_q : 4'b0000;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_din   = din_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.dm_done   = dm_done_q;
  assign bus.cpu_stall = (bus.if_req & ~if_done_q) | (bus.dm_req & ~dm_done_q);
  assign state_o       = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small byte-writable SRAM model.
module tb_mem_arbiter;
  logic       clk;
  logic       rst;
  logic [1:0] state;
  int         checks;
  int         errors;
  logic [31:0] sram [0:255];

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM: registered read data, byte-lane writes.
  always @(posedge clk) begin
    if (bus.mem_read) bus.mem_dout <= sram[bus.mem_addr[9:2]];
    for (int b = 0; b < 4; b++)
      if (bus.mem_write[b]) sram[bus.mem_addr[9:2]][b*8 +: 8] <= bus.mem_din[b*8 +: 8];
  end

  task automatic idle_inputs();
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'd0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 4'd0;
    bus.dm_addr  = 32'd0;
    bus.dm_wdata = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.if_req = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0 || bus.if_done !== 1'b0 || bus.dm_done !== 1'b0 || bus.mem_read !== 1'b0 ||
        bus.mem_write !== 4'd0 || bus.mem_addr !== 32'd0 || bus.mem_din !== 32'd0 ||
        bus.if_rdata !== 32'd0 || bus.dm_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs state=%0d rd=%b wr=%h addr=%h din=%h", state, bus.mem_read,
               bus.mem_write, bus.mem_addr, bus.mem_din);
    end
    checks++;
    if (bus.cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall got %b exp 1", bus.cpu_stall);
    end
    idle_inputs();
    #1;
    checks++;
    if (bus.cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall_idle got %b exp 0", bus.cpu_stall);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_if_read();
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    #1;
    checks++;
    if (bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL if_stall_T got %b exp 1", bus.cpu_stall); end
    @(negedge clk);
    checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_write !== 4'd0 || bus.mem_addr !== 32'h10) begin
      errors++;
      $display("FAIL if_issue rd=%b wr=%h addr=%h exp rd=1 wr=0 addr=10", bus.mem_read, bus.mem_write, bus.mem_addr);
    end
    checks++;
    if (bus.cpu_stall !== 1'b1 || bus.if_done !== 1'b0) begin
      errors++;
      $display("FAIL if_stall_T1 stall=%b done=%b exp 1/0", bus.cpu_stall, bus.if_done);
    end
    @(negedge clk);
    checks++;
    if (bus.cpu_stall !== 1'b1 || bus.mem_read !== 1'b0 || bus.if_done !== 1'b0) begin
      errors++;
      $display("FAIL if_resp stall=%b rd=%b done=%b exp 1/0/0", bus.cpu_stall, bus.mem_read, bus.if_done);
    end
    @(negedge clk);
    checks++;
    if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h00A00093 || bus.cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL if_done done=%b rdata=%h stall=%b exp 1/00a00093/0", bus.if_done, bus.if_rdata, bus.cpu_stall);
    end
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.if_done !== 1'b0 || bus.if_rdata !== 32'h00A00093) begin
      errors++;
      $display("FAIL if_done_pulse done=%b rdata=%h exp 0/00a00093", bus.if_done, bus.if_rdata);
    end
  endtask

  task automatic test_dm_write_read();
    @(negedge clk);
    bus.dm_req   = 1'b1;
    bus.dm_we    = 4'b0011;
    bus.dm_addr  = 32'h104;
    bus.dm_wdata = 32'h0000BEEF;
    @(negedge clk);
    bus.dm_wdata = 32'hDEAD0000;
    #1;
    checks++;
    if (bus.mem_write !== 4'b0011 || bus.mem_read !== 1'b0 || bus.mem_addr !== 32'h104 || bus.mem_din !== 32'h0000BEEF) begin
      errors++;
      $display("FAIL dm_wr_issue wr=%h rd=%b addr=%h din=%h exp 3/0/104/0000beef", bus.mem_write, bus.mem_read,
               bus.mem_addr, bus.mem_din);
    end
    @(negedge clk);
    checks++;
    if (bus.dm_done !== 1'b1 || bus.mem_write !== 4'd0 || bus.cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL dm_wr_done done=%b wr=%h stall=%b exp 1/0/0", bus.dm_done, bus.mem_write, bus.cpu_stall);
    end
    bus.dm_req = 1'b0;
    bus.dm_we  = 4'd0;
    @(negedge clk);
    bus.dm_req = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.dm_done !== 1'b1 || bus.dm_rdata !== 32'h0000BEEF) begin
      errors++;
      $display("FAIL dm_readback done=%b rdata=%h exp 1/0000beef", bus.dm_done, bus.dm_rdata);
    end
    bus.dm_req = 1'b0;
  endtask

  task automatic test_tie();
    do_reset();
    @(negedge clk);
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h20;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h30;
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 32'h20 || bus.mem_read !== 1'b1) begin
      errors++;
      $display("FAIL tie_first addr=%h rd=%b exp 20/1", bus.mem_addr, bus.mem_read);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.dm_done !== 1'b1 || bus.dm_rdata !== 32'h11111111 || bus.if_done !== 1'b0) begin
      errors++;
      $display("FAIL tie_dm_done done=%b rdata=%h exp 1/11111111", bus.dm_done, bus.dm_rdata);
    end
    bus.dm_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 32'h30 || bus.mem_read !== 1'b1) begin
      errors++;
      $display("FAIL tie_second addr=%h rd=%b exp 30/1", bus.mem_addr, bus.mem_read);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h22222222) begin
      errors++;
      $display("FAIL tie_if_done done=%b rdata=%h exp 1/22222222", bus.if_done, bus.if_rdata);
    end
    bus.if_req = 1'b0;
    @(negedge clk);
    bus.dm_req = 1'b1;
    bus.if_req = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 32'h20) begin
      errors++;
      $display("FAIL tie_again addr=%h exp 20", bus.mem_addr);
    end
    repeat (2) @(negedge clk);
    bus.dm_req = 1'b0;
    repeat (3) @(negedge clk);
    bus.if_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] order [$];
    int          n;
    do_reset();
    @(negedge clk);
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h20;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h30;
    n = 0;
    for (int c = 0; c < 24 && n < 4; c++) begin
      @(negedge clk);
      if (state == 2'd1) begin
        order.push_back(bus.mem_addr);
        n++;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL b2b_count got %0d grants exp 4", n);
    end else begin
      checks++;
      if (order[0] !== 32'h20 || order[1] !== 32'h30 || order[2] !== 32'h20 || order[3] !== 32'h30) begin
        errors++;
        $display("FAIL b2b_order got %h %h %h %h exp 20 30 20 30", order[0], order[1], order[2], order[3]);
      end
    end
    idle_inputs();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    bit seen;
    do_reset();
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h30;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0 || bus.if_done !== 1'b0 || bus.if_rdata !== 32'd0 || bus.mem_addr !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid state=%0d done=%b rdata=%h addr=%h exp 0/0/0/0", state, bus.if_done, bus.if_rdata,
               bus.mem_addr);
    end
    bus.if_req = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.if_done) seen = 1'b1;
      rst = 1'b0;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_done got %b exp 0", seen);
    end
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h00A00093) begin
      errors++;
      $display("FAIL rst_mid_clean done=%b rdata=%h exp 1/00a00093", bus.if_done, bus.if_rdata);
    end
    bus.if_req = 1'b0;
  endtask

  task automatic test_dm_rerequest();
    do_reset();
    @(negedge clk);
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h20;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.dm_done !== 1'b1) begin errors++; $display("FAIL rereq_done got %b exp 1", bus.dm_done); end
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || bus.dm_done !== 1'b0 || bus.cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL rereq_no_dup state=%0d done=%b stall=%b exp 0/0/1", state, bus.dm_done, bus.cpu_stall);
    end
    @(negedge clk);
    checks++;
    if (state !== 2'd1 || bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h20) begin
      errors++;
      $display("FAIL rereq_grant state=%0d rd=%b addr=%h exp 1/1/20", state, bus.mem_read, bus.mem_addr);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.dm_done !== 1'b1 || bus.dm_rdata !== 32'h11111111) begin
      errors++;
      $display("FAIL rereq_data done=%b rdata=%h exp 1/11111111", bus.dm_done, bus.dm_rdata);
    end
    bus.dm_req = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle_inputs();
    bus.mem_dout = 32'd0;
    for (int i = 0; i < 256; i++) sram[i] = 32'd0;
    sram[4]  = 32'h00A00093;
    sram[8]  = 32'h11111111;
    sram[12] = 32'h22222222;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_if_read();
    test_dm_write_read();
    test_tie();
    test_back_to_back();
    test_reset_mid_access();
    test_dm_rerequest();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port SRAM between the CPU's instruction-fetch port and data port, so a unified memory can replace the separate instruction and data memories. Each side drives a level request with address and write controls and receives a one-cycle `done` pulse with read data. The arbiter serializes accesses with a three-state FSM, applies alternating priority on conflicts, and produces a stall for the CPU while any request is outstanding.

## Interface
- No parameters. Data and address are 32 bits; byte write enables are 4 bits.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  instruction-fetch request (level).
- `if_addr`  in  32  fetch byte address.
- `if_rdata`  out  32  fetched word; valid while `if_done`=1.
- `if_done`  out  1  one-cycle fetch-complete pulse.
- `dm_req`  in  1  data request (level).
- `dm_we`  in  4  byte write enables; 0 means read.
- `dm_addr`  in  32  data byte address.
- `dm_wdata`  in  32  write data, already byte-lane aligned.
- `dm_rdata`  out  32  load word; valid while `dm_done`=1.
- `dm_done`  out  1  one-cycle data-complete pulse.
- `mem_read`  out  1  SRAM read strobe.
- `mem_write`  out  4  SRAM byte write strobes.
- `mem_addr`  out  32  SRAM address.
- `mem_din`  out  32  SRAM write data.
- `mem_dout`  in  32  SRAM read data, valid one cycle after `mem_read`.
- `cpu_stall`  out  1  `(if_req & ~if_done) | (dm_req & ~dm_done)`. Combinational.

## Operation
- FSM states:
  - IDLE: no access in flight.
  - ISSUE: SRAM strobes asserted.
  - RESP: read data returning.
- Registers: `grant` (0=IF, 1=DM) and `last_grant` (resets to IF).
- Eligible requests in IDLE: `if_req & ~if_done` and `dm_req & ~dm_done`. The requester being acknowledged in the current cycle is masked.
- Arbitration in IDLE:
  - Only one requester eligible: grant it.
  - Both eligible: grant the one that is not `last_grant`.
  - On grant: go to ISSUE. Capture the address, `dm_we` and `dm_wdata` into `mem_addr`, `mem_write` (a pending 4'b0 for IF) and `mem_din`. Set `grant` and `last_grant`.
- ISSUE:
  - Read (IF, or DM with `dm_we`=0): `mem_read`=1, `mem_write`=0. Next state RESP.
  - Write (DM with `dm_we`≠0): `mem_read`=0, `mem_write`=captured `dm_we`. Next state IDLE. Register `dm_done`=1 for the next cycle.
- RESP:
  - Strobes are 0.
  - Register `mem_dout` into `if_rdata` or `dm_rdata` according to `grant`.
  - Register the matching `done`=1. Next state IDLE.
- Strobes (`mem_read`, `mem_write`) are nonzero only in ISSUE. `mem_addr` and `mem_din` hold their last captured values otherwise.
- `done` pulses last exactly one cycle. Requesters drop `req` in the `done` cycle or re-raise it for a new access. Arbitration performed in that same cycle ignores the acknowledged side.
- Request inputs are captured only at grant; changes after grant are ignored.
- `if_rdata` and `dm_rdata` hold their values until the next read on that port.
- A DM read and a DM write follow the same rules except for latency.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE, `last_grant`=IF.
  - All outputs 0 except `cpu_stall`, which follows its equation.
- Request sampled in IDLE at cycle T:
  - ISSUE at T+1.
  - Read: RESP at T+2, `done` and `rdata` at T+3.
  - Write: `done` at T+2.
- Back-to-back traffic:
  - A new grant can occur in the `done` cycle if the other side is eligible.
  - The same side, re-requesting, is granted the cycle after its `done`.
  - Sustained throughput: one read per 3 cycles, one write per 2 cycles.
- Reset mid-access: the access is aborted and no `done` is generated. Any SRAM write already strobed is not undone.
- `cpu_stall` is 1 from request assertion through the cycle before `done`, and 0 in the `done` cycle.

## Test plan
- IF read of address 0x10 from reset, SRAM word 0x00A00093:
  - `mem_read`=1 with `mem_addr`=0x10 at T+1.
  - `if_done`=1 and `if_rdata`=0x00A00093 at T+3.
  - `cpu_stall`=1 over T..T+2.
- DM write `dm_we`=4'b0011, addr 0x104, wdata 0x0000BEEF:
  - `mem_write`=4'b0011, `mem_addr`=0x104, `mem_din`=0x0000BEEF at T+1.
  - `dm_done` at T+2.
  - A subsequent DM read returns 0x0000BEEF (with upper bytes preloaded to 0).
- Simultaneous `if_req` and `dm_req` after reset:
  - DM is granted first, IF second.
  - After that, a further tie goes to DM again, because `last_grant`=IF.
- Both sides hold their requests continuously, re-raising after each `done`: grants strictly alternate DM, IF, DM, IF, and neither side waits more than one other access.
- Assert `rst` in the RESP cycle of an IF read: no `if_done`, outputs 0 immediately, and a clean read after release.
- `dm_req` held high in its `dm_done` cycle with `if_req` low: no duplicate DM grant in that cycle, and the re-request is granted the next cycle.
